init_done_sequencer: RTL
========================

Name: init_done_sequencer

Overview:
- Parametrised successor to the device init-monitor wrapper.
- Takes NUM_CH asynchronous init-done / calibration-status flags (PCIE, SRAM, USRAM, XCVR, bank calib, ...), synchronises and glitch-filters each one, then waits for all unmasked flags.
- Releases NUM_CH fabric reset outputs one by one, in ascending index order, with a programmable gap between releases.
- Detects init timeout per channel, and re-enters the init wait if any done flag drops after release.

Parameters:
NUM_CH, 4, number of monitored flags and staged reset outputs (1..16)
SYNC_STAGES, 2, synchroniser flops per input (>=2)
FILTER_CYCLES, 16, consecutive synchronised-high cycles before a flag counts as done (>=1)
STAGE_DELAY, 256, cycles between successive reset releases (>=1)
TIMEOUT_CYCLES, 1048576, cycles allowed in WAIT_INIT before timeout (>=2)
TIMEOUT_EN, 1, 1 enables timeout detection; 0 waits indefinitely

Ports:
CLK  input  1  system clock
RESETN  input  1  asynchronous active-low reset
INIT_DONE_IN  input  NUM_CH  asynchronous done/status flags, active high
CH_MASK  input  NUM_CH  1 = ignore channel for completion, timeout and loss; quasi-static
RESTART  input  1  synchronous pulse; restarts the sequence from WAIT_INIT
RESET_N_OUT  output  NUM_CH  staged active-low resets; bit i released i-th
ALL_DONE  output  1  high while in RUN
TIMEOUT  output  1  high while in TO_ERR
TIMEOUT_CH  output  NUM_CH  unmasked channels not done at timeout; latched
STATE  output  3  FSM state: IDLE=0, WAIT_INIT=1, RELEASE=2, RUN=3, TO_ERR=4

Behaviour:
- Reset (RESETN low, asynchronous):
  - Synchronisers, filter counters, timers and stage index are cleared.
  - RESET_N_OUT=0, ALL_DONE=0, TIMEOUT=0, TIMEOUT_CH=0, STATE=IDLE.
  - Deassertion is taken synchronously; the block leaves IDLE on the first CLK edge after RESETN goes high.
- Filter, per channel:
  - Saturating counter flt[i] increments each cycle sync[i]=1 and clears to 0 on any cycle sync[i]=0.
  - done[i] = (flt[i]==FILTER_CYCLES), registered.
  - done[i] drops on the first synchronised low.
  - Latency from input rise to done[i]: SYNC_STAGES+FILTER_CYCLES cycles, +1 for asynchronous sampling.
- ok = AND over i of (done[i] | CH_MASK[i]).
- IDLE: unconditionally goes to WAIT_INIT.
- WAIT_INIT:
  - RESET_N_OUT=0. Timer counts from 0.
  - If ok, go to RELEASE with stage index=0 and gap counter=0.
  - Else, if TIMEOUT_EN and timer==TIMEOUT_CYCLES-1: go to TO_ERR and latch TIMEOUT_CH = ~done & ~CH_MASK.
  - ok and timeout in the same cycle: ok wins.
- RELEASE:
  - Gap counter counts 0..STAGE_DELAY-1. On reaching STAGE_DELAY-1, RESET_N_OUT[idx] is set to 1, idx increments and the counter clears.
  - The first release occurs STAGE_DELAY cycles after entering RELEASE; release k occurs k*STAGE_DELAY cycles after.
  - Masked channels are released in sequence like unmasked ones.
  - After bit NUM_CH-1 is released, go to RUN on the same edge; ALL_DONE rises one cycle later, registered.
- RUN: RESET_N_OUT all ones, ALL_DONE=1.
- Loss: ok=0 in RELEASE or RUN:
  - Next state is WAIT_INIT.
  - RESET_N_OUT is cleared to 0 (all bits) and ALL_DONE=0 on the same edge.
  - Timer restarts from 0.
- TO_ERR:
  - RESET_N_OUT=0, TIMEOUT=1, TIMEOUT_CH held.
  - A late ok does not exit the state; only RESTART or RESETN exits.
- RESTART (any state except IDLE):
  - Go to WAIT_INIT with RESET_N_OUT=0, timer=0, TIMEOUT=0 and TIMEOUT_CH=0.
  - RESTART has priority over every other transition, including ok and timeout in the same cycle.
  - Filter counters are not cleared.
- All channels masked: ok=1, so WAIT_INIT exits after one cycle.
- Counter widths are sized with $clog2 of the respective parameter; there is no wrap: the timer stops in TO_ERR and flt saturates.

Test Plan:
- All test cases use NUM_CH=4, SYNC_STAGES=2, FILTER_CYCLES=4, STAGE_DELAY=8, TIMEOUT_CYCLES=64, unless stated otherwise.
- Nominal: raise INIT_DONE_IN bits 0..3 at cycles 5, 10, 15, 20 -> RELEASE entered after bit 3 filters, about cycle 27. RESET_N_OUT goes 0001, 0011, 0111, 1111 at +8, +16, +24, +32 cycles. ALL_DONE=1 one cycle after 1111; STATE=3.
- Glitch filter: pulse INIT_DONE_IN[2] high for 3 cycles with the others held high -> no RELEASE. Hold it high for 6 cycles -> RELEASE entered.
- Timeout: hold INIT_DONE_IN=1011 -> STATE=4 and TIMEOUT=1 after 64 cycles in WAIT_INIT, TIMEOUT_CH=0100. Raise bit 2 -> state stays 4. Pulse RESTART -> WAIT_INIT, then normal release.
- Mask: CH_MASK=0100 with INIT_DONE_IN=1011 -> no timeout; all four RESET_N_OUT released at 8-cycle intervals.
- Loss mid-release: drop INIT_DONE_IN[0] when RESET_N_OUT=0011 -> next edge RESET_N_OUT=0000 and STATE=1. Re-raise bit 0 -> the sequence restarts from bit 0.
- Reset mid-operation: assert RESETN low in RUN -> all outputs reset immediately (asynchronous). After release, IDLE then WAIT_INIT; TIMEOUT_EN=0 variant never enters TO_ERR after 1000 cycles with inputs low.

Source files
------------

// File: rtl/init_done_sequencer.sv
// Staged fabric-reset release: filters NUM_CH async init-done flags, then
// releases one reset output per STAGE_DELAY cycles, with timeout and loss recovery.

module init_done_filter #(
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic async_i,
    output logic done_o
);
    localparam int FW = $clog2(FILTER_CYCLES + 1);
    localparam logic [FW-1:0] FMAX = FW'(FILTER_CYCLES);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [FW-1:0]          flt_q, flt_d;
    logic                   done_q, done_d;

    // done is computed from the next counter value so it falls on the same
    // edge that the counter clears on the first synchronised low
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], async_i};
        flt_d  = flt_q;
        if (!sync_q[SYNC_STAGES-1]) begin
            flt_d = '0;
        end else if (flt_q != FMAX) begin
            flt_d = flt_q + FW'(1);
        end
        done_d = (flt_d == FMAX);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
            flt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            flt_q  <= flt_d;
            done_q <= done_d;
        end
    end

    assign done_o = done_q;
endmodule

module init_done_sequencer #(
    parameter int NUM_CH         = 4,
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_CYCLES  = 16,
    parameter int STAGE_DELAY    = 256,
    parameter int TIMEOUT_CYCLES = 1048576,
    parameter int TIMEOUT_EN     = 1
) (
    input  logic              CLK,
    input  logic              RESETN,
    input  logic [NUM_CH-1:0] INIT_DONE_IN,
    input  logic [NUM_CH-1:0] CH_MASK,
    input  logic              RESTART,
    output logic [NUM_CH-1:0] RESET_N_OUT,
    output logic              ALL_DONE,
    output logic              TIMEOUT,
    output logic [NUM_CH-1:0] TIMEOUT_CH,
    output logic [2:0]        STATE
);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam int GW = (STAGE_DELAY > 1) ? $clog2(STAGE_DELAY) : 1;
    localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [GW-1:0] GLAST = GW'(STAGE_DELAY - 1);
    localparam logic [IW-1:0] ILAST = IW'(NUM_CH - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT  = 3'd1,
        S_REL   = 3'd2,
        S_RUN   = 3'd3,
        S_TOERR = 3'd4
    } state_e;

    state_e            state_q, state_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [GW-1:0]     gap_q, gap_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [NUM_CH-1:0] rst_q, rst_d;
    logic [NUM_CH-1:0] toch_q, toch_d;
    logic              ad_q, ad_d;
    logic [NUM_CH-1:0] done;
    logic              ok;
    logic              restart_hit;

    init_done_filter #(
        .SYNC_STAGES  (SYNC_STAGES),
        .FILTER_CYCLES(FILTER_CYCLES)
    ) u_flt [NUM_CH-1:0] (
        .clk_i  (CLK),
        .rst_ni (RESETN),
        .async_i(INIT_DONE_IN),
        .done_o (done)
    );

    assign ok          = &(done | CH_MASK);
    assign restart_hit = RESTART && (state_q != S_IDLE);

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            gap_q   <= '0;
            idx_q   <= '0;
            rst_q   <= '0;
            toch_q  <= '0;
            ad_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            gap_q   <= gap_d;
            idx_q   <= idx_d;
            rst_q   <= rst_d;
            toch_q  <= toch_d;
            ad_q    <= ad_d;
        end
    end

    // RESTART overrides everything; in WAIT a coincident ok beats the timeout
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  state_d = S_WAIT;
            S_WAIT: begin
                if (ok) begin
                    state_d = S_REL;
                end else if ((TIMEOUT_EN != 0) && (timer_q == TLAST)) begin
                    state_d = S_TOERR;
                end
            end
            S_REL: begin
                if (!ok) begin
                    state_d = S_WAIT;
                end else if ((gap_q == GLAST) && (idx_q == ILAST)) begin
                    state_d = S_RUN;
                end
            end
            S_RUN:   if (!ok) state_d = S_WAIT;
            S_TOERR: state_d = S_TOERR;
            default: state_d = S_IDLE;
        endcase
        if (restart_hit) begin
            state_d = S_WAIT;
        end
    end

    // Datapath follows the chosen next state, so loss and restart clear the
    // resets on the same edge the FSM leaves RELEASE/RUN
    always_comb begin
        timer_d = timer_q;
        gap_d   = gap_q;
        idx_d   = idx_q;
        rst_d   = rst_q;
        toch_d  = toch_q;
        unique case (state_d)
            S_WAIT: begin
                rst_d  = '0;
                gap_d  = '0;
                idx_d  = '0;
                toch_d = '0;
                if ((state_q != S_WAIT) || restart_hit) begin
                    timer_d = '0;
                end else if (timer_q != TLAST) begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_REL: begin
                if (state_q != S_REL) begin
                    gap_d = '0;
                    idx_d = '0;
                    rst_d = '0;
                end else if (gap_q == GLAST) begin
                    rst_d[idx_q] = 1'b1;
                    idx_d        = idx_q + IW'(1);
                    gap_d        = '0;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            S_RUN: begin
                rst_d = '1;
                gap_d = '0;
                idx_d = '0;
            end
            S_TOERR: begin
                rst_d = '0;
                if (state_q == S_WAIT) begin
                    toch_d = ~done & ~CH_MASK;
                end
            end
            default: begin
                timer_d = '0;
                gap_d   = '0;
                idx_d   = '0;
                rst_d   = '0;
                toch_d  = '0;
            end
        endcase
    end

    assign ad_d = (state_q == S_RUN) && (state_d == S_RUN);

    always_comb begin
        RESET_N_OUT = rst_q;
        ALL_DONE    = ad_q;
        TIMEOUT     = (state_q == S_TOERR);
        TIMEOUT_CH  = toch_q;
        STATE       = state_q;
    end
endmodule
